// File: rtl/popcount25_weight_gen.sv
// Streams every WIDTH-bit vector of a requested Hamming weight in ascending numeric
// order over valid/ready, tagging each beat with its weight, run index and last flag.
module popcount25_weight_gen #(
    parameter int WIDTH = 25,
    parameter int CW    = 5,
    parameter int IDXW  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CW-1:0]     req_weight,
    input  logic [IDXW-1:0]   req_limit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_vec,
    output logic [CW-1:0]     out_weight,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_last,
    output logic              done,
    output logic              err,
    input  logic              abort
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH:0]  ONE_W1  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [IDXW-1:0] IDX_ONE = {{(IDXW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   K_MAX   = CW'(WIDTH);

    state_t            state_q, state_d;
    logic [CW-1:0]     k_q, k_d;
    logic [IDXW-1:0]   limit_q, limit_d;
    logic [WIDTH-1:0]  vec_q, vec_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [WIDTH:0]    x;
    logic [WIDTH:0]    c;
    logic [WIDTH:0]    r;
    logic [CW-1:0]     ctz;
    logic [WIDTH-1:0]  sh;
    logic [WIDTH-1:0]  vec_step;
    logic              last_hit;
    logic              is_run;

    // Bits of c whose position index has bit b set; OR-ing them encodes the one-hot c.
    function automatic logic [WIDTH:0] ctz_mask(input int b);
        logic [WIDTH:0] m;
        m = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            m[i] = ((i >> b) & 1) != 0;
        end
        return m;
    endfunction

    // Gosper step on a 26-bit copy so the carry out of the top bit stays visible.
    assign x = {1'b0, vec_q};
    assign c = x & (~x + ONE_W1);
    assign r = x + c;

    genvar gi;
    generate
        for (gi = 0; gi < CW; gi++) begin : g_ctz
            assign ctz[gi] = |(c & ctz_mask(gi));
        end
    endgenerate

    assign sh       = WIDTH'(((r ^ x) >> 2) >> ctz);
    assign vec_step = r[WIDTH-1:0] | sh;

    assign is_run   = (state_q == S_RUN);
    // r overflowing into bit WIDTH means the ones already occupy the top k positions.
    assign last_hit = (k_q == '0) || r[WIDTH] ||
                      ((limit_q != '0) && (idx_q == (limit_q - IDX_ONE)));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        limit_d = limit_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_weight > K_MAX) begin
                            err_d = 1'b1;
                        end else begin
                            k_d     = req_weight;
                            limit_d = req_limit;
                            vec_d   = WIDTH'((ONE_W1 << req_weight) - ONE_W1);
                            idx_d   = '0;
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (out_ready) begin
                        if (last_hit) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            vec_d = vec_step;
                            idx_d = idx_q + IDX_ONE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            limit_q <= '0;
            vec_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            limit_q <= limit_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign out_valid  = is_run;
    assign out_vec    = vec_q;
    assign out_weight = k_q;
    assign out_idx    = idx_q;
    assign out_last   = is_run && last_hit;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_popcount25_weight_gen.sv
// Randomised scoreboard bench: a colex combination model predicts every beat, and an
// independent negedge monitor pops and compares whenever the DUT completes a handshake.
module tb_popcount25_weight_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_weight = '0;
    logic [15:0] req_limit = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] out_vec;
    logic [4:0]  out_weight;
    logic [15:0] out_idx;
    logic        out_last;
    logic        done;
    logic        err;
    logic        abort = 1'b0;

    popcount25_weight_gen dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_weight(req_weight), .req_limit(req_limit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_weight(out_weight), .out_idx(out_idx),
        .out_last(out_last), .done(done), .err(err), .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] vec;
        logic [4:0]  w;
        logic [15:0] idx;
        logic        last;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    last_hs_edge = -1;
    int    first_hs_edge = -1;
    logic [24:0] last_vec_seen;
    logic [15:0] last_idx_seen;
    int    rdy_mode = 0;  // 0 always, 1 toggle, 2 random, 3 manual

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: k-subsets of {0..24} in colex order equal vectors in ascending numeric order.
    task automatic push_run(input int k, input int limit, input int maxpush);
        int p[25];
        int n;
        bit more;
        beat_t b;
        n = 0;
        more = 1;
        if (k == 0) begin
            b.vec = '0; b.w = '0; b.idx = '0; b.last = 1'b1;
            if (maxpush > 0) q.push_back(b);
            return;
        end
        for (int i = 0; i < k; i++) p[i] = i;
        while (more) begin
            bit top_full, lim_hit;
            b.vec = '0;
            for (int i = 0; i < k; i++) b.vec[p[i]] = 1'b1;
            top_full = (p[0] == 25 - k);
            lim_hit  = (limit != 0) && (n == limit - 1);
            b.w    = 5'(k);
            b.idx  = 16'(n);
            b.last = top_full || lim_hit;
            if (n < maxpush) q.push_back(b);
            n++;
            if (b.last) begin
                more = 0;
            end else begin
                for (int j = 0; j < k; j++) begin
                    int bound;
                    bound = (j == k - 1) ? 25 : p[j + 1];
                    if (p[j] + 1 < bound) begin
                        p[j]++;
                        for (int i = 0; i < j; i++) p[i] = i;
                        break;
                    end
                end
            end
        end
    endtask

    // Monitor: compares each accepted beat and checks held outputs during stalls.
    initial begin
        logic pv, pr, pab;
        logic [24:0] pvec;
        logic [15:0] pidx;
        logic plast;
        beat_t e;
        pv = 0; pr = 0; pab = 0; pvec = '0; pidx = '0; plast = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0;
            end else begin
                if (pv && !pr && !pab && out_valid) begin
                    chk("stall_vec", out_vec, pvec);
                    chk("stall_idx", out_idx, pidx);
                    chk("stall_last", out_last, plast);
                end
                chk("req_ready_vs_valid", req_ready, !out_valid);
                if (out_valid && out_ready && !abort) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got vec 0x%0h idx %0d expected no beat", out_vec, out_idx);
                    end else begin
                        e = q.pop_front();
                        chk("beat_vec", out_vec, e.vec);
                        chk("beat_weight", out_weight, e.w);
                        chk("beat_idx", out_idx, e.idx);
                        chk("beat_last", out_last, e.last);
                    end
                    if (out_idx == 0) first_hs_edge = cyc + 1;
                    if (out_last) last_hs_edge = cyc + 1;
                    last_vec_seen = out_vec;
                    last_idx_seen = out_idx;
                end
                pv = out_valid; pr = out_ready; pab = abort;
                pvec = out_vec; pidx = out_idx; plast = out_last;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_out_vec"}, out_vec, 0);
        chk({tag, "_out_weight"}, out_weight, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic do_req(input int k, input int limit, input int maxpush);
        bit ok;
        ok = (k <= 25);
        @(posedge clk);
        #1;
        chk("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_weight = 5'(k);
        req_limit  = 16'(limit);
        if (ok) push_run(k, limit, maxpush);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (ok) begin
            chk("first_beat_latency", out_valid, 1);
            chk("req_ready_in_run", req_ready, 0);
        end else begin
            chk("err_pulse", err, 1);
            chk("err_no_valid", out_valid, 0);
            chk("err_req_ready", req_ready, 1);
            @(posedge clk);
            #1;
            chk("err_one_cycle", err, 0);
            chk("err_still_no_valid", out_valid, 0);
        end
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1;
                chk("done_timing", cyc, last_hs_edge);
                chk("ready_at_done", req_ready, 1);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done", budget);
        end
        chk("queue_drained", q.size(), 0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("post_reset");

        rdy_mode = 0;
        do_req(0, 0, 1 << 30);
        wait_done(20);
        chk("k0_vec", last_vec_seen, 25'h0000000);

        do_req(25, 0, 1 << 30);
        wait_done(20);
        chk("k25_vec", last_vec_seen, 25'h1FFFFFF);

        do_req(1, 0, 1 << 30);
        wait_done(60);
        chk("k1_consecutive", last_hs_edge - first_hs_edge, 24);
        chk("k1_last_vec", last_vec_seen, 25'h1000000);

        do_req(2, 0, 1 << 30);
        wait_done(400);
        chk("k2_last_vec", last_vec_seen, 25'h1800000);
        chk("k2_last_idx", last_idx_seen, 299);

        do_req(26, 0, 0);
        do_req(31, 5, 0);

        rdy_mode = 1;
        do_req(3, 4, 1 << 30);
        wait_done(40);
        chk("k3_lim4_last_vec", last_vec_seen, 25'h000000E);
        chk("k3_lim4_last_idx", last_idx_seen, 3);

        // Abort after exactly two accepted beats.
        rdy_mode = 3;
        out_ready = 1'b0;
        do_req(3, 0, 2);
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        abort = 1'b1;
        chk("abort_pre_valid", out_valid, 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_valid_drop", out_valid, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_queue", q.size(), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", done, 0);
        end

        // Asynchronous reset in the middle of a long run.
        rdy_mode = 0;
        do_req(2, 0, 1 << 30);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("rst_no_done", done, 0);
            chk("rst_no_valid", out_valid, 0);
        end

        rdy_mode = 2;
        for (int t = 0; t < 8; t++) begin
            int k, lim;
            k   = $urandom_range(0, 25);
            lim = $urandom_range(1, 30);
            do_req(k, lim, 1 << 30);
            wait_done(400);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
